// File: rtl/shiftreg_pkg.sv
// shiftreg_pkg: shared shift-register mode codes, burst FSM states and helpers
package shiftreg_pkg;
  localparam int MODE_W = 3;
  typedef enum logic [MODE_W-1:0] {
    HOLD  = 3'd0,
    LEFT  = 3'd1,
    RIGHT = 3'd2,
    PLOAD = 3'd3,
    ROTL  = 3'd4,
    ROTR  = 3'd5,
    ASR   = 3'd6,
    CLEAR = 3'd7
  } mode_e;
  typedef enum logic {IDLE, BURST} state_e;
  function automatic logic is_shift(input mode_e m);
    return m == LEFT || m == RIGHT || m == ROTL || m == ROTR || m == ASR;
  endfunction
endpackage

// File: rtl/shiftreg_next.sv
// shiftreg_next: combinational next-value function of the shift register for one mode
module shiftreg_next
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_cur,
  input  mode_e            i_mode,
  input  logic             i_ser,
  input  logic [WIDTH-1:0] i_pin,
  output logic [WIDTH-1:0] o_next
);
  always_comb begin
    o_next = i_cur;
    case (i_mode)
      LEFT:    o_next = {i_cur[WIDTH-2:0], i_ser};
      RIGHT:   o_next = {i_ser, i_cur[WIDTH-1:1]};
      PLOAD:   o_next = i_pin;
      ROTL:    o_next = {i_cur[WIDTH-2:0], i_cur[WIDTH-1]};
      ROTR:    o_next = {i_cur[0], i_cur[WIDTH-1:1]};
      ASR:     o_next = {i_cur[WIDTH-1], i_cur[WIDTH-1:1]};
      CLEAR:   o_next = '0;
      default: o_next = i_cur;
    endcase
  end
endmodule

// File: rtl/shiftreg_burst.sv
// shiftreg_burst: shift register with direct modes and a counted shift-burst engine
module shiftreg_burst
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  parallelIn,
  input  logic              serialIn,
  input  logic              start,
  input  logic [CNTW-1:0]   shiftCount,
  output logic [WIDTH-1:0]  parallelOut,
  output logic              serialOutMsb,
  output logic              serialOutLsb,
  output logic              busy,
  output logic              done
);
  state_e           r_state, w_state_nx;
  logic [CNTW-1:0]  r_cnt, w_cnt_nx;
  mode_e            r_mode, w_mode_nx, w_op, w_mode_in;
  logic [WIDTH-1:0] r_data, w_data_nx;
  logic             r_done, w_done_nx, w_idle, w_go;
  // r_cnt counts shifts still pending after the current edge; the burst ends when it reaches 1
  always_comb begin
    w_mode_in  = mode_e'(mode);
    w_idle     = r_state == IDLE;
    w_go       = w_idle && start && is_shift(w_mode_in);
    w_op       = !w_idle ? r_mode : (w_go && shiftCount == '0) ? HOLD : w_mode_in;
    w_state_nx = w_idle ? ((w_go && shiftCount > CNTW'(1)) ? BURST : IDLE)
                        : (r_cnt == CNTW'(1) ? IDLE : BURST);
    w_cnt_nx   = !w_idle ? r_cnt - CNTW'(1)
                         : (w_go && shiftCount != '0) ? shiftCount - CNTW'(1) : r_cnt;
    w_mode_nx  = w_go ? w_mode_in : r_mode;
    w_done_nx  = w_idle ? (w_go && shiftCount <= CNTW'(1)) : r_cnt == CNTW'(1);
  end
  shiftreg_next #(.WIDTH(WIDTH)) u_next (
    .i_cur (r_data),
    .i_mode(w_op),
    .i_ser (serialIn),
    .i_pin (parallelIn),
    .o_next(w_data_nx)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_mode  <= HOLD;
      r_data  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_mode  <= w_mode_nx;
      r_data  <= w_data_nx;
      r_done  <= w_done_nx;
    end
  end
  assign parallelOut  = r_data;
  assign serialOutMsb = r_data[WIDTH-1];
  assign serialOutLsb = r_data[0];
  assign busy         = r_state == BURST;
  assign done         = r_done;
endmodule

// File: tb/tb_shiftreg_burst.sv
// tb_shiftreg_burst: directed plus random checks of shiftreg_burst against a behavioural model
module tb_shiftreg_burst;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);
  logic          clk = 1'b0;
  logic          reset, sin, start;
  logic [2:0]    mode;
  logic [W-1:0]  pin, pout;
  logic [CW-1:0] cnt;
  logic          msb, lsb, busy, done;
  int            n_tests = 0, n_fail = 0;
  int            m_data = 0, m_rem = 0, m_mode = 0;
  bit            m_done = 0;
  always #5 clk = ~clk;
  shiftreg_burst #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .mode(mode), .parallelIn(pin), .serialIn(sin),
    .start(start), .shiftCount(cnt), .parallelOut(pout), .serialOutMsb(msb),
    .serialOutLsb(lsb), .busy(busy), .done(done)
  );
  function automatic int apply(input int m, input int v, input int s, input int p);
    case (m)
      1:       return ((v * 2) + s) % 256;
      2:       return (v / 2) + s * 128;
      3:       return p;
      4:       return ((v * 2) % 256) + (v / 128);
      5:       return (v / 2) + (v % 2) * 128;
      6:       return (v / 2) + (v / 128) * 128;
      7:       return 0;
      default: return v;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input bit r, input int m, input int p, input bit s, input bit st, input int n);
    reset = r; mode = 3'(m); pin = 8'(p); sin = s; start = st; cnt = CW'(n);
    @(posedge clk);
    if (r) begin
      m_data = 0; m_rem = 0; m_mode = 0; m_done = 0;
    end else if (m_rem > 0) begin
      m_data = apply(m_mode, m_data, int'(s), p);
      m_rem--;
      m_done = m_rem == 0;
    end else if (st && (m inside {1, 2, 4, 5, 6})) begin
      m_mode = m;
      m_done = n <= 1;
      if (n > 0) begin
        m_data = apply(m, m_data, int'(s), p);
        m_rem  = n - 1;
      end
    end else begin
      m_data = apply(m, m_data, int'(s), p);
      m_done = 0;
    end
    #1;
    chk("data", 32'(pout), 32'(m_data));
    chk("busy", 32'(busy), 32'(m_rem > 0));
    chk("done", 32'(done), 32'(m_done));
    chk("msb",  32'(msb),  32'((m_data / 128) % 2));
    chk("lsb",  32'(lsb),  32'(m_data % 2));
  endtask
  task automatic idle(input int m, input int p, input bit s);
    step(0, m, p, s, 0, 0);
  endtask
  initial begin
    step(1, 3, 'hFF, 1, 0, 0);
    step(1, 3, 'hFF, 1, 0, 0);
    chk("reset_val", 32'(pout), 32'h00);
    idle(3, 'hA5, 0); idle(4, 0, 0); chk("rotl", 32'(pout), 32'h4B);
    idle(3, 'hA5, 0); idle(5, 0, 0); chk("rotr", 32'(pout), 32'hD2);
    idle(3, 'hA5, 0); idle(6, 0, 0); chk("asr_neg", 32'(pout), 32'hD2);
    idle(3, 'h25, 0); idle(6, 0, 0); chk("asr_pos", 32'(pout), 32'h12);
    idle(7, 0, 0); chk("clear", 32'(pout), 32'h00);
    idle(3, 'h81, 0);
    step(0, 1, 0, 1, 1, 3); chk("b_left1", 32'(pout), 32'h03);
    idle(0, 0, 0);          chk("b_left2", 32'(pout), 32'h06);
    idle(0, 0, 1);          chk("b_left3", 32'(pout), 32'h0D); chk("b_done", 32'(done), 32'h1);
    idle(0, 0, 0);          chk("b_done_end", 32'(done), 32'h0);
    idle(3, 'hF0, 0);
    step(0, 2, 0, 0, 1, 4);
    for (int i = 0; i < 3; i++) step(0, 3, 'hFF, 0, 1, 7);
    chk("isolate", 32'(pout), 32'h0F);
    idle(3, 'h3C, 0);
    step(0, 1, 0, 1, 1, 0); chk("n0_val", 32'(pout), 32'h3C); chk("n0_done", 32'(done), 32'h1);
    step(0, 1, 0, 1, 1, 5);
    step(1, 1, 0, 1, 0, 0);
    step(1, 1, 0, 1, 0, 0); chk("rst_abort", 32'(pout), 32'h00); chk("rst_nodone", 32'(done), 32'h0);
    idle(0, 0, 0);
    idle(3, 'h81, 0);
    step(0, 2, 0, 0, 1, 2);
    idle(0, 0, 0);
    step(0, 4, 0, 0, 1, 2); chk("b2b_busy", 32'(busy), 32'h1);
    idle(0, 0, 0);          chk("b2b_val", 32'(pout), 32'h80);
    idle(7, 0, 0);
    step(0, 1, 0, 1, 1, 12);
    for (int i = 0; i < 10; i++) idle(0, 0, 1);
    chk("n12_notdone", 32'(done), 32'h0);
    idle(0, 0, 1);          chk("n12_val", 32'(pout), 32'hFF); chk("n12_done", 32'(done), 32'h1);
    idle(0, 0, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 7), $urandom_range(0, 255),
           1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, $urandom_range(0, 12));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
